ball_sequencer: RTL and testbench

BALL_SEQUENCER -- requirements
Module: ball_sequencer

---
 rtl/ball_sequencer.sv | 144 ++++++++++++++
 tb/tb_ball_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_sequencer.sv
// ball_sequencer: frame-driven four-ball bouncer inside an arena whose margin pulses in and out
module ball_sequencer #(
    parameter int SPEED      = 2,
    parameter int SIZE       = 16,
    parameter int MAX_MARGIN = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [3:0]  ball_en,
    output logic [39:0] ball_x,
    output logic [39:0] ball_y,
    output logic [7:0]  margin,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, BORDER, LOAD, UPDATE, DONE} state_t;
    state_t             r_state;
    logic [1:0]         r_idx;
    logic               r_en;
    logic [7:0]         r_margin;
    logic               r_up;
    logic signed [10:0] r_min;
    logic signed [10:0] r_xmax;
    logic signed [10:0] r_ymax;
    logic [9:0]         r_x [4];
    logic [9:0]         r_y [4];
    logic [3:0]         r_dxn;
    logic [3:0]         r_dyn;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;
    logic               w_top;
    logic               w_bot;
    logic               w_up_next;
    logic [7:0]         w_margin_next;
    logic signed [10:0] w_step;
    logic signed [10:0] w_cx;
    logic signed [10:0] w_cy;
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic [9:0]         w_x_next;
    logic [9:0]         w_y_next;
    logic               w_dxn_next;
    logic               w_dyn_next;

    // Margin bounce: reverse at either end, and saturate so MAX_MARGIN=0 pins the margin at 0
    always_comb begin
        w_top         = r_up && (r_margin == 8'(MAX_MARGIN));
        w_bot         = !r_up && (r_margin == 8'd0);
        w_up_next     = w_top ? 1'b0 : (w_bot ? 1'b1 : r_up);
        w_margin_next = w_up_next ? ((r_margin == 8'(MAX_MARGIN)) ? r_margin : r_margin + 8'd1)
                                  : ((r_margin == 8'd0) ? r_margin : r_margin - 8'd1);
    end

    // Shared step/clamp datapath for whichever ball r_idx selects
    always_comb begin
        w_step     = 11'(SPEED);
        w_cx       = {1'b0, r_x[r_idx]};
        w_cy       = {1'b0, r_y[r_idx]};
        w_nx       = r_dxn[r_idx] ? w_cx - w_step : w_cx + w_step;
        w_ny       = r_dyn[r_idx] ? w_cy - w_step : w_cy + w_step;
        w_x_next   = (w_nx <= r_min) ? r_min[9:0] : ((w_nx >= r_xmax) ? r_xmax[9:0] : w_nx[9:0]);
        w_y_next   = (w_ny <= r_min) ? r_min[9:0] : ((w_ny >= r_ymax) ? r_ymax[9:0] : w_ny[9:0]);
        w_dxn_next = (w_nx <= r_min) ? 1'b0 : ((w_nx >= r_xmax) ? 1'b1 : r_dxn[r_idx]);
        w_dyn_next = (w_ny <= r_min) ? 1'b0 : ((w_ny >= r_ymax) ? 1'b1 : r_dyn[r_idx]);
    end

    // Sequencer: margin step, then LOAD/UPDATE per ball, then a one-cycle DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_en      <= 1'b0;
            r_margin  <= 8'd0;
            r_up      <= 1'b1;
            r_min     <= '0;
            r_xmax    <= '0;
            r_ymax    <= '0;
            r_dxn     <= 4'b0000;
            r_dyn     <= 4'b1010;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_x[k] <= 10'(64 + 128 * k);
                r_y[k] <= 10'(48 + 96 * k);
            end
        end else begin
            r_overrun <= tick && (r_state != IDLE);
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tick) begin
                        r_state <= BORDER;
                        r_busy  <= 1'b1;
                    end
                end
                BORDER: begin
                    r_margin <= w_margin_next;
                    r_up     <= w_up_next;
                    r_idx    <= 2'd0;
                    r_state  <= LOAD;
                end
                LOAD: begin
                    r_en    <= ball_en[r_idx];
                    r_min   <= {3'b000, r_margin};
                    r_xmax  <= 11'(640 - SIZE) - {3'b000, r_margin};
                    r_ymax  <= 11'(480 - SIZE) - {3'b000, r_margin};
                    r_state <= UPDATE;
                end
                UPDATE: begin
                    if (r_en) begin
                        r_x[r_idx]   <= w_x_next;
                        r_y[r_idx]   <= w_y_next;
                        r_dxn[r_idx] <= w_dxn_next;
                        r_dyn[r_idx] <= w_dyn_next;
                    end
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign ball_x[10*i +: 10] = r_x[i];
        assign ball_y[10*i +: 10] = r_y[i];
    end

    assign margin  = r_margin;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;
endmodule

// File: tb/tb_ball_sequencer.sv
// tb_ball_sequencer: scoreboard bench for ball_sequencer with default, MAX_MARGIN=3 and MAX_MARGIN=0 instances
module tb_ball_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [3:0]  ball_en;
    logic [39:0] bx, by, bx3, by3, bx0, by0;
    logic [7:0]  mg, mg3, mg0;
    logic        bs, dn, ov, bs3, dn3, ov3, bs0, dn0, ov0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct packed {
        logic [7:0]  m;
        logic [39:0] x;
        logic [39:0] y;
    } exp_t;
    exp_t q[$];

    int m_margin, m_up;
    int mx[4], my[4], mdx[4], mdy[4];

    always #5 clk = ~clk;

    ball_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick), .ball_en(ball_en),
        .ball_x(bx), .ball_y(by), .margin(mg), .busy(bs), .done(dn), .overrun(ov)
    );
    ball_sequencer #(.MAX_MARGIN(3)) dut3 (
        .clk(clk), .reset(reset), .tick(tick), .ball_en(ball_en),
        .ball_x(bx3), .ball_y(by3), .margin(mg3), .busy(bs3), .done(dn3), .overrun(ov3)
    );
    ball_sequencer #(.MAX_MARGIN(0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .ball_en(ball_en),
        .ball_x(bx0), .ball_y(by0), .margin(mg0), .busy(bs0), .done(dn0), .overrun(ov0)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t snap();
        exp_t e;
        e.m = 8'(m_margin);
        for (int i = 0; i < 4; i++) begin
            e.x[10*i +: 10] = 10'(mx[i]);
            e.y[10*i +: 10] = 10'(my[i]);
        end
        return e;
    endfunction

    task automatic model_reset();
        m_margin = 0;
        m_up = 1;
        for (int i = 0; i < 4; i++) begin
            mx[i]  = 64 + 128 * i;
            my[i]  = 48 + 96 * i;
            mdx[i] = 2;
            mdy[i] = (i % 2 == 1) ? -2 : 2;
        end
    endtask

    task automatic step(inout int p, inout int d, input int lo, input int hi);
        int np;
        np = p + d;
        if (np <= lo) begin
            p = lo;
            d = 2;
        end else if (np >= hi) begin
            p = hi;
            d = -2;
        end else begin
            p = np;
        end
    endtask

    task automatic model_frame(input logic [3:0] en);
        if (m_up == 1) begin
            if (m_margin == 100) begin
                m_up = 0;
                m_margin = m_margin - 1;
            end else m_margin = m_margin + 1;
        end else begin
            if (m_margin == 0) begin
                m_up = 1;
                m_margin = m_margin + 1;
            end else m_margin = m_margin - 1;
        end
        for (int i = 0; i < 4; i++)
            if (en[i]) begin
                step(mx[i], mdx[i], m_margin, 640 - m_margin - 16);
                step(my[i], mdy[i], m_margin, 480 - m_margin - 16);
            end
    endtask

    task automatic do_reset();
        tick = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        q.delete();
    endtask

    task automatic run_frame(input logic [3:0] en);
        int   lat;
        logic busy_ok;
        exp_t e;
        ball_en = en;
        model_frame(en);
        q.push_back(snap());
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (dn === 1'b1) begin
                lat = n;
                n_checks++;
                if (bs !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_in_done: got %b expected 0", bs);
                end
            end else if (bs !== 1'b1) busy_ok = 1'b0;
        end
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL busy_during_sequence: busy dropped before done");
        end
        n_checks++;
        if (lat != 10) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles expected 10 (0 means timeout)", lat);
        end
        e = q.pop_front();
        n_checks++;
        if (mg !== e.m) begin
            n_fail++;
            $display("FAIL margin: got %0d expected %0d", mg, e.m);
        end
        n_checks++;
        if (bx !== e.x) begin
            n_fail++;
            $display("FAIL ball_x: got %h expected %h", bx, e.x);
        end
        n_checks++;
        if (by !== e.y) begin
            n_fail++;
            $display("FAIL ball_y: got %h expected %h", by, e.y);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        tick = 1'b0;
        ball_en = 4'b1111;
        reset = 1'b1;
        model_reset();
        e = snap();
        @(negedge clk);
        n_checks++;
        if ({bs, dn, ov} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/overrun %b expected 000", {bs, dn, ov});
        end
        n_checks++;
        if (mg !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_margin: got %0d expected 0", mg);
        end
        n_checks++;
        if (bx !== e.x || by !== e.y) begin
            n_fail++;
            $display("FAIL reset_positions: got %h/%h expected %h/%h", bx, by, e.x, e.y);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bs !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_tick: busy got %b expected 0", bs);
        end
    endtask

    task automatic test_one_tick();
        do_reset();
        run_frame(4'b1111);
        n_checks++;
        if (mg !== 8'd1 || bx[9:0] !== 10'd66 || by[9:0] !== 10'd50) begin
            n_fail++;
            $display("FAIL one_tick_ball0: got m=%0d (%0d,%0d) expected m=1 (66,50)", mg, bx[9:0], by[9:0]);
        end
        n_checks++;
        if (bx[19:10] !== 10'd194 || by[19:10] !== 10'd142) begin
            n_fail++;
            $display("FAIL one_tick_ball1: got (%0d,%0d) expected (194,142)", bx[19:10], by[19:10]);
        end
    endtask

    task automatic test_margin_bounce();
        int exp_m[7] = '{1, 2, 3, 2, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            run_frame(4'b1111);
            n_checks++;
            if (mg3 !== 8'(exp_m[i])) begin
                n_fail++;
                $display("FAIL margin_bounce[%0d]: got %0d expected %0d", i, mg3, exp_m[i]);
            end
        end
    endtask

    task automatic test_edge_bounce();
        do_reset();
        for (int t = 1; t <= 281; t++) begin
            run_frame(4'b0001);
            if (t == 208) begin
                n_checks++;
                if (by0[9:0] !== 10'd464) begin
                    n_fail++;
                    $display("FAIL edge_y_208: got %0d expected 464", by0[9:0]);
                end
            end
            if (t == 209) begin
                n_checks++;
                if (by0[9:0] !== 10'd462) begin
                    n_fail++;
                    $display("FAIL edge_y_209: got %0d expected 462", by0[9:0]);
                end
            end
            if (t == 280) begin
                n_checks++;
                if (bx0[9:0] !== 10'd624) begin
                    n_fail++;
                    $display("FAIL edge_x_280: got %0d expected 624", bx0[9:0]);
                end
            end
            if (t == 281) begin
                n_checks++;
                if (bx0[9:0] !== 10'd622 || mg0 !== 8'd0) begin
                    n_fail++;
                    $display("FAIL edge_x_281: got x=%0d m=%0d expected x=622 m=0", bx0[9:0], mg0);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int   dcount, ocount, opos, dpos;
        exp_t e;
        do_reset();
        ball_en = 4'b1111;
        model_frame(4'b1111);
        q.push_back(snap());
        dcount = 0;
        ocount = 0;
        opos = 0;
        dpos = 0;
        @(negedge clk);
        tick = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (dn === 1'b1) begin
                dcount++;
                dpos = n;
            end
            if (ov === 1'b1) begin
                ocount++;
                opos = n;
            end
            tick = (n == 3);
        end
        n_checks++;
        if (ocount != 1 || opos != 4) begin
            n_fail++;
            $display("FAIL overrun_pulse: got count=%0d at=%0d expected count=1 at=4", ocount, opos);
        end
        n_checks++;
        if (dcount != 1 || dpos != 10) begin
            n_fail++;
            $display("FAIL overrun_done: got count=%0d at=%0d expected count=1 at=10", dcount, dpos);
        end
        e = q.pop_front();
        n_checks++;
        if (bx !== e.x || by !== e.y || mg !== e.m) begin
            n_fail++;
            $display("FAIL overrun_positions: got %h/%h m=%0d expected %h/%h m=%0d", bx, by, mg, e.x, e.y, e.m);
        end
    endtask

    task automatic test_enable_mask();
        do_reset();
        run_frame(4'b0101);
        n_checks++;
        if (bx[19:10] !== 10'd192 || by[19:10] !== 10'd144 || bx[39:30] !== 10'd448 || by[39:30] !== 10'd336) begin
            n_fail++;
            $display("FAIL mask_held: got b1=(%0d,%0d) b3=(%0d,%0d) expected (192,144) (448,336)",
                     bx[19:10], by[19:10], bx[39:30], by[39:30]);
        end
        n_checks++;
        if (bx[29:20] !== 10'd322 || by[29:20] !== 10'd242) begin
            n_fail++;
            $display("FAIL mask_moved: got b2=(%0d,%0d) expected (322,242)", bx[29:20], by[29:20]);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        ball_en = 4'b1111;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        model_reset();
        e = snap();
        #1;
        n_checks++;
        if ({bs, dn, ov} !== 3'b000 || mg !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got busy/done/overrun %b m=%0d expected 000 m=0", {bs, dn, ov}, mg);
        end
        n_checks++;
        if (bx !== e.x || by !== e.y) begin
            n_fail++;
            $display("FAIL mid_reset_positions: got %h/%h expected %h/%h", bx, by, e.x, e.y);
        end
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bs !== 1'b0) begin
            n_fail++;
            $display("FAIL no_resume: busy got %b expected 0", bs);
        end
        run_frame(4'b1111);
        n_checks++;
        if (mg !== 8'd1 || bx[9:0] !== 10'd66 || by[9:0] !== 10'd50 || bx[19:10] !== 10'd194 || by[19:10] !== 10'd142) begin
            n_fail++;
            $display("FAIL after_mid_reset: got m=%0d b0=(%0d,%0d) b1=(%0d,%0d) expected m=1 (66,50) (194,142)",
                     mg, bx[9:0], by[9:0], bx[19:10], by[19:10]);
        end
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        ball_en = 4'b1111;
        test_reset();
        test_one_tick();
        test_margin_bounce();
        test_overrun();
        test_enable_mask();
        test_reset_mid();
        test_edge_bounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
